// File: rtl/fifo_serializer.sv
// Pops words from an upstream fifo and shifts them out MSB first.
// Optional even-parity bit per frame when SER_PARITY_EN is defined.
module fifo_serializer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             avail,
  output logic             pop,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_sof,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE,
    SHIFT
  } state_t;
`endif

  state_t           st;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             word_end;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  // Word is finished on the edge its final serial bit is accepted.
  always_comb begin
`ifdef SER_PARITY_EN
    word_end = (st == PARITY) && ser_ready;
`else
    word_end = (st == SHIFT) && (cnt == LAST) && ser_ready;
`endif
  end

  // Dequeue only when idle or exactly at a frame boundary.
  always_comb begin
    pop = 1'b0;
    if (reset) begin
      if (st == IDLE)
        pop = avail;
      else if (word_end)
        pop = avail;
    end
  end

  // Serial outputs come straight from state, forced low in reset.
  always_comb begin
    ser_valid = reset && (st != IDLE);
    busy      = reset && (st != IDLE);
    ser_sof   = reset && (st == SHIFT) && (cnt == '0);
`ifdef SER_PARITY_EN
    ser_out   = reset && ((st == PARITY) ? par : sh[WIDTH-1]);
`else
    ser_out   = reset && sh[WIDTH-1];
`endif
  end

  // Frame state machine: load, shift on acceptance, chain next word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st  <= IDLE;
      sh  <= '0;
      cnt <= '0;
`ifdef SER_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      unique case (st)
        IDLE: begin
          if (avail) begin
            sh  <= in;
            cnt <= '0;
`ifdef SER_PARITY_EN
            par <= ^in;
`endif
            st  <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (cnt == LAST) begin
`ifdef SER_PARITY_EN
              st <= PARITY;
`else
              if (avail) begin
                sh  <= in;
                cnt <= '0;
              end else begin
                st  <= IDLE;
              end
`endif
            end else begin
              sh  <= sh << 1;
              cnt <= cnt + 1'b1;
            end
          end
        end
`ifdef SER_PARITY_EN
        PARITY: begin
          if (ser_ready) begin
            if (avail) begin
              sh  <= in;
              cnt <= '0;
              par <= ^in;
              st  <= SHIFT;
            end else begin
              st  <= IDLE;
            end
          end
        end
`endif
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: vector table, directed corners,
// then random traffic against a queue-based frame model.
module tb_fifo_serializer;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in = '0;
  logic         avail = 1'b0;
  logic         ser_ready = 1'b1;
  logic         pop;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_sof;
  logic         busy;

  int nchk = 0;
  int nerr = 0;

  fifo_serializer #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .in(in),
    .avail(avail),
    .pop(pop),
    .ser_out(ser_out),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .ser_sof(ser_sof),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         r;
    logic         av;
    logic [W-1:0] d;
    logic         rdy;
    logic         ep;
    logic         ev;
    logic         eo;
    logic         es;
  } vec_t;

  typedef struct {
    logic b;
    logic s;
  } sbit_t;

  vec_t         tbl[$];
  logic [W-1:0] fq[$];
  sbit_t        eq[$];

  task automatic cmp(string nm, logic a, logic e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, step a clock.
  task automatic vec(string nm, vec_t v);
    reset     = v.r;
    avail     = v.av;
    in        = v.d;
    ser_ready = v.rdy;
    #1;
    cmp({nm, ".pop"}, pop, v.ep);
    cmp({nm, ".valid"}, ser_valid, v.ev);
    cmp({nm, ".busy"}, busy, v.ev);
    cmp({nm, ".sof"}, ser_sof, v.es);
    if (v.ev || !v.r)
      cmp({nm, ".out"}, ser_out, v.eo);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic r, logic av, logic [W-1:0] d,
                              logic rdy, logic ep, logic ev,
                              logic eo, logic es);
    vec_t v;
    v.r = r; v.av = av; v.d = d; v.rdy = rdy;
    v.ep = ep; v.ev = ev; v.eo = eo; v.es = es;
    return v;
  endfunction

  task automatic push_word(logic [W-1:0] w);
    for (int k = W - 1; k >= 0; k--)
      eq.push_back('{w[k], 1'(k == W - 1)});
`ifdef SER_PARITY_EN
    eq.push_back('{^w, 1'b0});
`endif
  endtask

  initial begin
    // reset with avail held, then word 11, then 11/01 back-to-back
    tbl.push_back(mk(0, 1, 2'b11, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2'b11, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2'b11, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 1, 1, 0));
`ifdef SER_PARITY_EN
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 1, 0, 0));
`endif
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 0, 0, 0));
`ifdef SER_PARITY_EN
    tbl.push_back(mk(1, 1, 2'b01, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2'b11, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 2'b11, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 2'b11, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 1, 0, 0));
`else
    tbl.push_back(mk(1, 1, 2'b11, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2'b01, 1, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 2'b01, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 1, 1, 0));
`endif
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      vec($sformatf("tbl[%0d]", i), tbl[i]);

    // stall on the first bit of 10
    vec("stall.pop", mk(1, 1, 2'b10, 1, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vec($sformatf("stall.hold%0d", i), mk(1, 0, 2'b00, 0, 0, 1, 1, 1));
    vec("stall.b0", mk(1, 0, 2'b00, 1, 0, 1, 1, 1));
    vec("stall.b1", mk(1, 0, 2'b00, 1, 0, 1, 0, 0));
`ifdef SER_PARITY_EN
    vec("stall.par", mk(1, 0, 2'b00, 1, 0, 1, 1, 0));
`endif
    vec("stall.idle", mk(1, 0, 2'b00, 1, 0, 0, 0, 0));

    // reset after the first bit of 10
    vec("mid.pop", mk(1, 1, 2'b10, 1, 1, 0, 0, 0));
    vec("mid.b0", mk(1, 0, 2'b00, 1, 0, 1, 1, 1));
    vec("mid.rst", mk(0, 0, 2'b00, 1, 0, 0, 0, 0));
    vec("mid.after0", mk(1, 0, 2'b00, 1, 0, 0, 0, 0));
    vec("mid.after1", mk(1, 0, 2'b00, 1, 0, 0, 0, 0));

    // random traffic against the frame model
    for (int c = 0; c < 4000; c++) begin
      logic r, av, rdy, ep, ev;
      logic [W-1:0] w;
      r = ($urandom_range(0, 149) != 0);
      if (fq.size() < 4 && $urandom_range(0, 2) == 0)
        fq.push_back(W'($urandom));
      av  = (fq.size() > 0);
      rdy = ($urandom_range(0, 3) != 0);
      reset     = r;
      avail     = av;
      in        = av ? fq[0] : W'($urandom);
      ser_ready = rdy;
      #1;
      ev = r && (eq.size() > 0);
      ep = r && av &&
           (eq.size() == 0 || (eq.size() == 1 && rdy));
      cmp("rnd.pop", pop, ep);
      cmp("rnd.valid", ser_valid, ev);
      cmp("rnd.busy", busy, ev);
      if (ev) begin
        cmp("rnd.out", ser_out, eq[0].b);
        cmp("rnd.sof", ser_sof, eq[0].s);
      end else begin
        cmp("rnd.sof", ser_sof, 1'b0);
      end
      @(posedge clk);
      if (!r) begin
        eq.delete();
      end else begin
        if (ev && rdy)
          void'(eq.pop_front());
        if (ep) begin
          w = fq.pop_front();
          push_word(w);
        end
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 2, giving the word width consumed from the upstream fifo.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-low reset; reset==0 sampled on a clk rising edge resets the block.
REQ-004 Port in, input, WIDTH bits: fifo head word (fifo out), valid whenever avail==1.
REQ-005 Port avail, input, 1 bit: fifo holds at least one word.
REQ-006 Port pop, output, 1 bit: dequeue request to the fifo, at most one per word.
REQ-007 Port ser_out, output, 1 bit: serial data bit.
REQ-008 Port ser_valid, output, 1 bit: ser_out is valid this cycle.
REQ-009 Port ser_ready, input, 1 bit: downstream accepts ser_out when ser_valid&&ser_ready at a clk edge.
REQ-010 Port ser_sof, output, 1 bit: high together with the first bit of each word.
REQ-011 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and PARITY; PARITY exists only with SER_PARITY_EN.
REQ-013 In IDLE: pop = avail, combinationally; on an edge with avail==1, load in into the shift register, clear the bit counter, go to SHIFT.
REQ-014 Latency: the first bit of a word SHALL be on ser_out with ser_valid=1 in the cycle after the edge on which that word was popped.
REQ-015 In SHIFT: ser_valid=1; ser_out = current MSB; bits SHALL go MSB first.
REQ-016 A bit SHALL advance only on an edge where ser_valid&&ser_ready; with ser_ready==0, ser_out, ser_sof and the counter SHALL hold.
REQ-017 ser_sof SHALL be 1 only while the counter is 0 in SHIFT.
REQ-018 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and count accepted bits 0..WIDTH-1.
REQ-019 On acceptance of bit WIDTH-1 without parity: if avail==1, pop=1 that cycle, load in, and stay in SHIFT with counter 0; otherwise go to IDLE.
REQ-020 Back-to-back words SHALL therefore stream with no ser_valid bubble.
REQ-021 pop SHALL be 0 in every cycle not covered by REQ-013 or REQ-019, and 0 whenever reset==0.
REQ-022 The block SHALL never pop while a word is partially shifted.

Reset
REQ-023 On reset: state=IDLE, shift register=0, counter=0, parity accumulator=0.
REQ-024 During and after reset: ser_out=0, ser_valid=0, ser_sof=0, busy=0, pop=0.
REQ-025 Reset mid-word SHALL discard the remaining bits; the popped word is lost and SHALL NOT be re-popped.
REQ-026 The first word after reset release SHALL start per REQ-013.

Configuration
REQ-027 Macro SER_PARITY_EN: when defined, after bit WIDTH-1 is accepted the FSM SHALL enter PARITY and present the even-parity bit (XOR of the word) with ser_valid=1, ser_sof=0.
REQ-028 On acceptance of the parity bit, the next-word behaviour of REQ-019 applies.
REQ-029 Without SER_PARITY_EN: no PARITY state and no parity logic; frames are exactly WIDTH bits.

Verification (WIDTH=2, ser_ready=1 unless stated)
REQ-030 Reset low 2 cycles with avail=1 -> pop=0, ser_valid=0, busy=0 throughout; in=11, avail=1 after release -> pop pulse 1 cycle, then ser_out 1,1, ser_sof on the first bit only, then IDLE.
REQ-031 Words 11 then 01 with avail held -> ser_out 1,1,0,1 with ser_valid continuous and exactly 2 pop pulses, the second coinciding with acceptance of the 2nd bit.
REQ-032 in=10; ser_ready=0 for 3 cycles on the first bit -> ser_out=1 and ser_sof=1 held 3 cycles; then 1,0; no extra pop.
REQ-033 Reset asserted after the first bit of 10 -> ser_valid=0 the next cycle; with avail=0 afterwards, no further pop and no output.
REQ-034 With SER_PARITY_EN, words 01 then 11 -> ser_out 0,1,1, 1,1,0; ser_sof on the 1st and 4th bits.
